// File: rtl/plru_pkg.sv
// Shared tree-PLRU helpers: touch update, leaf-to-way mapping and node-index sizing.
// Supports up to PlruMaxAssoc ways. Vectors are sized for that maximum and truncated by callers.
package plru_pkg;

  localparam int unsigned PlruMaxAssoc  = 64;
  localparam int unsigned PlruMaxBits   = PlruMaxAssoc - 1;
  localparam int unsigned PlruMaxLevels = $clog2(PlruMaxAssoc);
  localparam int unsigned PlruNodeW     = $clog2(2 * PlruMaxAssoc - 1);

  typedef logic [PlruNodeW-1:0]   plru_node_t;
  typedef logic [PlruMaxBits-1:0] plru_bits_t;

  // Walk root-to-leaf along the way index and point every visited node away from it.
  function automatic plru_bits_t plru_touch(input plru_bits_t  bits,
                                            input int unsigned way,
                                            input int unsigned levels);
    plru_bits_t  res;
    int unsigned node;
    logic        dir;
    res  = bits;
    node = 0;
    for (int unsigned lvl = 0; lvl < PlruMaxLevels; lvl++) begin
      if (lvl < levels) begin
        dir = ((way >> (levels - 32'd1 - lvl)) & 32'd1) != 32'd0;
        if (dir) res = res & ~(plru_bits_t'(1) << node);
        else     res = res | (plru_bits_t'(1) << node);
        node = 32'd2 * node + (dir ? 32'd2 : 32'd1);
      end
    end
    return res;
  endfunction

  function automatic int unsigned plru_leaf_to_way(input int unsigned node,
                                                   input int unsigned assoc);
    return node - (assoc - 32'd1);
  endfunction

endpackage

// File: rtl/plru_level_stage.sv
// One tree level of the victim search: picks the child indicated by the snapshot bit at the
// current node and registers it along with the search's set and bit snapshot.
module plru_level_stage
  import plru_pkg::*;
#(
  parameter int unsigned s_assoc = 8,
  parameter int unsigned s_index = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [s_index-1:0] in_set,
  input  plru_node_t         in_node,
  input  logic [s_assoc-2:0] in_bits,
  output logic               out_valid,
  output logic [s_index-1:0] out_set,
  output plru_node_t         out_node,
  output logic [s_assoc-2:0] out_bits
);

  localparam int unsigned NBits = s_assoc - 1;

  logic       dir;
  plru_node_t node_d;
  logic       take;

  assign dir    = |(in_bits & (NBits'(1) << in_node));
  assign node_d = (in_node << 1) + plru_node_t'(dir) + plru_node_t'(1);
  assign take   = in_valid & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_set   <= '0;
      out_node  <= '0;
      out_bits  <= '0;
    end else begin
      out_valid <= take;
      if (take) begin
        out_set  <= in_set;
        out_node <= node_d;
        out_bits <= in_bits;
      end
    end
  end

endmodule

// File: rtl/plru_victim_pipe.sv
// Pipelined tree-PLRU victim engine: per-set PLRU bits, one-level-per-stage victim search,
// single-cycle touches. Optional PLRU_AUTO_TOUCH_EN also touches each reported victim.
module plru_victim_pipe
  import plru_pkg::*;
#(
  parameter int unsigned s_assoc = 8,
  parameter int unsigned s_width = $clog2(s_assoc),
  parameter int unsigned s_sets  = 16,
  parameter int unsigned s_index = $clog2(s_sets)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               find_valid,
  input  logic [s_index-1:0] find_set,
  input  logic               flush,
  input  logic               touch_valid,
  input  logic [s_index-1:0] touch_set,
  input  logic [s_width-1:0] touch_way,
  output logic               victim_valid,
  output logic [s_index-1:0] victim_set,
  output logic [s_width-1:0] victim_way,
  output logic               busy
);

  localparam int unsigned NBits = s_assoc - 1;

  logic [NBits-1:0]   plru_q [s_sets];
  logic [NBits-1:0]   plru_d [s_sets];

  logic [s_width:0]   st_valid;
  logic [s_index-1:0] st_set  [s_width+1];
  plru_node_t         st_node [s_width+1];
  logic [NBits-1:0]   st_bits [s_width+1];
  logic [s_width-1:0] fin_way;
  logic               unused_bits;

  // Stage 0 input is the pre-touch snapshot of the searched set.
  assign st_valid[0] = find_valid;
  assign st_set[0]   = find_set;
  assign st_node[0]  = '0;
  assign st_bits[0]  = plru_q[find_set];

  for (genvar l = 0; l < s_width; l++) begin : g_level
    plru_level_stage #(
      .s_assoc(s_assoc),
      .s_index(s_index)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (st_valid[l]),
      .in_set   (st_set[l]),
      .in_node  (st_node[l]),
      .in_bits  (st_bits[l]),
      .out_valid(st_valid[l+1]),
      .out_set  (st_set[l+1]),
      .out_node (st_node[l+1]),
      .out_bits (st_bits[l+1])
    );
  end

  assign unused_bits  = ^st_bits[s_width];
  assign fin_way      = s_width'(plru_leaf_to_way(32'(st_node[s_width]), s_assoc));
  assign victim_valid = st_valid[s_width];
  assign victim_set   = victim_valid ? st_set[s_width] : '0;
  assign victim_way   = victim_valid ? fin_way : '0;
  assign busy         = |st_valid[s_width:1];

  // Auto touch is applied before the explicit one so the explicit touch wins on shared nodes.
  always_comb begin
    plru_d = plru_q;
`ifdef PLRU_AUTO_TOUCH_EN
    if (victim_valid) begin
      plru_d[st_set[s_width]] = NBits'(plru_touch(plru_bits_t'(plru_d[st_set[s_width]]),
                                                  32'(fin_way), s_width));
    end
`endif
    if (touch_valid) begin
      plru_d[touch_set] = NBits'(plru_touch(plru_bits_t'(plru_d[touch_set]),
                                            32'(touch_way), s_width));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < s_sets; i++) plru_q[i] <= '0;
    end else begin
      plru_q <= plru_d;
    end
  end

endmodule

// File: tb/tb_plru_victim_pipe.sv
// Directed bench for plru_victim_pipe (8 ways, 16 sets); expectations follow PLRU_AUTO_TOUCH_EN.
module tb_plru_victim_pipe;

  logic       clk;
  logic       rst_n;
  logic       find_valid;
  logic [3:0] find_set;
  logic       flush;
  logic       touch_valid;
  logic [3:0] touch_set;
  logic [2:0] touch_way;
  logic       victim_valid;
  logic [3:0] victim_set;
  logic [2:0] victim_way;
  logic       busy;

  int total = 0;
  int bad   = 0;

`ifdef PLRU_AUTO_TOUCH_EN
  localparam int unsigned ExpT4 [4] = '{4, 4, 2, 0};
  localparam int unsigned ExpT6b = 4;
`else
  localparam int unsigned ExpT4 [4] = '{0, 0, 4, 0};
  localparam int unsigned ExpT6b = 0;
`endif

  plru_victim_pipe u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .find_valid  (find_valid),
    .find_set    (find_set),
    .flush       (flush),
    .touch_valid (touch_valid),
    .touch_set   (touch_set),
    .touch_way   (touch_way),
    .victim_valid(victim_valid),
    .victim_set  (victim_set),
    .victim_way  (victim_way),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one find, then check the result three cycles later.
  task automatic find_expect(input string tag, input logic [3:0] s, input logic [2:0] w);
    find_valid = 1'b1;
    find_set   = s;
    tick();
    find_valid = 1'b0;
    tick();
    tick();
    chk({tag, "_vv"}, 32'(victim_valid), 32'd1);
    chk({tag, "_set"}, 32'(victim_set), 32'(s));
    chk({tag, "_way"}, 32'(victim_way), 32'(w));
  endtask

  initial begin
    rst_n       = 1'b0;
    find_valid  = 1'b0;
    find_set    = '0;
    flush       = 1'b0;
    touch_valid = 1'b0;
    touch_set   = '0;
    touch_way   = '0;
    #12;
    chk("rst_vv", 32'(victim_valid), 32'd0);
    chk("rst_set", 32'(victim_set), 32'd0);
    chk("rst_way", 32'(victim_way), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Test 1: latency and untouched set.
    find_valid = 1'b1;
    find_set   = 4'd0;
    tick();
    find_valid = 1'b0;
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_vv_c1", 32'(victim_valid), 32'd0);
    tick();
    chk("t1_vv_c2", 32'(victim_valid), 32'd0);
    tick();
    chk("t1_vv_c3", 32'(victim_valid), 32'd1);
    chk("t1_set", 32'(victim_set), 32'd0);
    chk("t1_way", 32'(victim_way), 32'd0);
    tick();
    chk("t1_pulse", 32'(victim_valid), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // Test 2: touch way 0 steers the search to the right half.
    touch_valid = 1'b1;
    touch_set   = 4'd2;
    touch_way   = 3'd0;
    tick();
    touch_valid = 1'b0;
    find_expect("t2", 4'd2, 3'd4);

    // Test 3: touching every way in order leaves way 0 least recent.
    for (int w = 0; w < 8; w++) begin
      touch_valid = 1'b1;
      touch_set   = 4'd1;
      touch_way   = 3'(w);
      tick();
    end
    touch_valid = 1'b0;
    find_expect("t3", 4'd1, 3'd0);
    tick();

    // Test 4: back-to-back finds complete in issue order.
    find_valid = 1'b1;
    find_set   = 4'd0;
    tick();
    find_set = 4'd1;
    tick();
    find_set = 4'd2;
    tick();
    chk("t4_vv0", 32'(victim_valid), 32'd1);
    chk("t4_set0", 32'(victim_set), 32'd0);
    chk("t4_way0", 32'(victim_way), 32'(ExpT4[0]));
    find_set = 4'd3;
    tick();
    find_valid = 1'b0;
    chk("t4_vv1", 32'(victim_valid), 32'd1);
    chk("t4_set1", 32'(victim_set), 32'd1);
    chk("t4_way1", 32'(victim_way), 32'(ExpT4[1]));
    tick();
    chk("t4_vv2", 32'(victim_valid), 32'd1);
    chk("t4_set2", 32'(victim_set), 32'd2);
    chk("t4_way2", 32'(victim_way), 32'(ExpT4[2]));
    tick();
    chk("t4_vv3", 32'(victim_valid), 32'd1);
    chk("t4_set3", 32'(victim_set), 32'd3);
    chk("t4_way3", 32'(victim_way), 32'(ExpT4[3]));
    tick();
    chk("t4_vv_end", 32'(victim_valid), 32'd0);

    // Test 5a: flush kills an in-flight search.
    find_valid = 1'b1;
    find_set   = 4'd5;
    tick();
    find_valid = 1'b0;
    chk("t5_busy_c1", 32'(busy), 32'd1);
    tick();
    flush = 1'b1;
    chk("t5_busy_c2", 32'(busy), 32'd1);
    tick();
    flush = 1'b0;
    chk("t5_busy_flushed", 32'(busy), 32'd0);
    chk("t5_vv_c3", 32'(victim_valid), 32'd0);
    tick();
    chk("t5_vv_c4", 32'(victim_valid), 32'd0);

    // Test 5b: find in the flush cycle is dropped; touch in the flush cycle commits.
    find_valid  = 1'b1;
    find_set    = 4'd7;
    flush       = 1'b1;
    touch_valid = 1'b1;
    touch_set   = 4'd7;
    touch_way   = 3'd0;
    tick();
    find_valid  = 1'b0;
    flush       = 1'b0;
    touch_valid = 1'b0;
    chk("t5b_busy", 32'(busy), 32'd0);
    tick();
    tick();
    chk("t5b_vv", 32'(victim_valid), 32'd0);
    find_expect("t5b_touch", 4'd7, 3'd4);
    tick();

    // Test 5c: find and touch on the same set in one cycle; find sees the old bits.
    find_valid  = 1'b1;
    find_set    = 4'd6;
    touch_valid = 1'b1;
    touch_set   = 4'd6;
    touch_way   = 3'd0;
    tick();
    find_valid  = 1'b0;
    touch_valid = 1'b0;
    tick();
    tick();
    chk("t5c_vv", 32'(victim_valid), 32'd1);
    chk("t5c_way", 32'(victim_way), 32'd0);
    tick();
    find_expect("t5c_after", 4'd6, 3'd4);
    tick();

    // Test 6: async reset clears PLRU bits; two finds four cycles apart.
    rst_n = 1'b0;
    #2;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    find_expect("t6_rst_bits", 4'd2, 3'd0);
    tick();
    find_expect("t6_first", 4'd3, 3'd0);
    tick();
    find_expect("t6_second", 4'd3, 3'(ExpT6b));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
